bus_arbit_mux: RTL and testbench
================================

Name: bus_arbit_mux

Overview:
Two-master bus arbiter with an integrated master-side multiplexer. It sits directly upstream of the bus address decoder. It picks one of two masters and drives that master's request, address, write-enable and write data onto the shared bus. The decoder consumes m_req and s_addr from this block to generate slave selects.

Parameters:
ADDR_W, 16, width of master/bus address
DATA_W, 32, width of write data
MAX_HOLD, 8, max consecutive granted cycles while the other master waits; 0 disables preemption

Ports:
clk  input  1  bus clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 bus request
m0_wr  input  1  master 0 write enable
m0_address  input  ADDR_W  master 0 address
m0_dout  input  DATA_W  master 0 write data
m1_req  input  1  master 1 bus request
m1_wr  input  1  master 1 write enable
m1_address  input  ADDR_W  master 1 address
m1_dout  input  DATA_W  master 1 write data
m0_grant  output  1  master 0 owns bus
m1_grant  output  1  master 1 owns bus
m_req  output  1  bus request to address decoder (granted master's req)
s_addr  output  ADDR_W  bus address to decoder/slaves
s_wr  output  1  bus write enable
s_din  output  DATA_W  bus write data

Behaviour:
- One clock; reset is asynchronous and active-high. Asserting reset immediately forces state M0_GNT and hold_cnt=0, regardless of clock.
- Reset output values: m0_grant=1, m1_grant=0; mux outputs follow master 0 inputs (m_req=m0_req, etc.).
- State register, 2 states: M0_GNT (reset/park state), M1_GNT. Exactly one grant is high at all times, decoded directly from state: m0_grant=(state==M0_GNT), m1_grant=(state==M1_GNT).
- M0_GNT transitions:
  - m1_req=1 and m0_req=0 -> M1_GNT.
  - m1_req=1 and m0_req=1 and MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> M1_GNT (preempt).
  - Otherwise stay, including when both requests are 0.
- M1_GNT transitions:
  - m1_req=0 -> M0_GNT (release parks on master 0).
  - m1_req=1 and m0_req=1 and MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> M0_GNT (preempt).
  - Otherwise stay.
- hold_cnt:
  - Width $clog2(MAX_HOLD+1), minimum 1.
  - Increments each cycle the state is unchanged while both requests are 1.
  - Cleared to 0 on any state change, or in any cycle where the non-granted master's req=0.
  - Saturates at MAX_HOLD-1; never wraps.
- Latency: a grant change appears 1 clk edge after the qualifying request pattern is sampled. The mux is combinational from state, so bus outputs switch in the same cycle as the grant.
- Mux: in M0_GNT, {m_req,s_addr,s_wr,s_din} = {m0_req,m0_address,m0_wr,m0_dout}; in M1_GNT, the m1_* equivalents. The non-granted master's inputs never reach the bus.
- m_req=0 whenever the granted master is not requesting, even if the other master is. The downstream decoder then outputs no select that cycle.
- Simultaneous first request from both masters in M0_GNT: master 0 keeps the bus (priority to park owner).
- Preemption takes effect regardless of transfer state. Masters must watch their grant and retry if it drops.
- No X propagation: all state is reset. Requests are sampled only at clk edges.

Test Plan:
- Reset: assert reset mid-cycle with m1 granted -> m0_grant=1, m1_grant=0 immediately, hold_cnt=0; m0_address=16'h0100 appears on s_addr.
- Single master: m0_req=1, m0_wr=1, m0_address=16'h0004, m0_dout=32'hDEADBEEF for 5 cycles -> grant stays on m0; bus outputs equal m0 values every cycle; m_req=1.
- Handover: m0_req=0, m1_req=1, m1_address=16'h7010 -> after 1 edge m1_grant=1 and s_addr=16'h7010; drop m1_req -> after 1 edge m0_grant=1, m_req=0.
- Fairness, MAX_HOLD=4: both requests held high -> grant alternates m0,m1,m0 every 4 cycles; hold_cnt resets at each switch.
- MAX_HOLD=0: both requests high for 20 cycles from reset -> m0 keeps grant throughout.
- Idle with a waiting peer: m0 granted with m0_req=0 and m1_req=0 -> stays in M0_GNT with m_req=0; assert m1_req in the same cycle as m0_req -> m0 retains grant.

Source files
------------

// File: rtl/bus_arbit_mux.sv
// Two-master bus arbiter with integrated master-side mux. Park owner is master 0; a bounded
// hold counter lets the waiting master preempt after MAX_HOLD contended cycles.
module bus_arbit_mux #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              m_req,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_wr,
  output logic [DATA_W-1:0] s_din
);

  localparam int unsigned CntW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CntW-1:0] HoldMax = CntW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {StM0Gnt, StM1Gnt} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] hold_q, hold_d;
  logic            both_req;
  logic            preempt;
  logic            other_req;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    both_req  = m0_req & m1_req;
    preempt   = (MAX_HOLD != 0) && both_req && (hold_q == HoldMax);
    other_req = (state_q == StM0Gnt) ? m1_req : m0_req;

    unique case (state_q)
      StM0Gnt: begin
        if ((m1_req && !m0_req) || preempt) state_d = StM1Gnt;
      end
      StM1Gnt: begin
        if (!m1_req || preempt) state_d = StM0Gnt;
      end
      default: state_d = StM0Gnt;
    endcase

    // Counter only measures contended cycles of the current owner; saturates, never wraps.
    if (state_d != state_q || !other_req) begin
      hold_d = '0;
    end else if (both_req && hold_q != HoldMax) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StM0Gnt;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    m0_grant = (state_q == StM0Gnt);
    m1_grant = (state_q == StM1Gnt);
    if (state_q == StM1Gnt) begin
      m_req  = m1_req;
      s_addr = m1_address;
      s_wr   = m1_wr;
      s_din  = m1_dout;
    end else begin
      m_req  = m0_req;
      s_addr = m0_address;
      s_wr   = m0_wr;
      s_din  = m0_dout;
    end
  end

endmodule

// File: tb/tb_bus_arbit_mux.sv
// Directed bench for bus_arbit_mux: vector table plus hand sequences for reset, mid-cycle
// request changes and the MAX_HOLD=0 (no preemption) variant.
module tb_bus_arbit_mux;

  localparam logic [15:0] A0 = 16'h0004;
  localparam logic [31:0] D0 = 32'hDEADBEEF;
  localparam logic [15:0] A1 = 16'h7010;
  localparam logic [31:0] D1 = 32'h12345678;

  logic        clk, reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [15:0] m0_address, m1_address;
  logic [31:0] m0_dout, m1_dout;

  logic        g0, g1, mreq, swr;
  logic [15:0] saddr;
  logic [31:0] sdin;
  logic        n_g0, n_g1, n_mreq, n_swr;
  logic [15:0] n_saddr;
  logic [31:0] n_sdin;

  int checks = 0;
  int errors = 0;

  bus_arbit_mux #(.ADDR_W(16), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
    .m0_grant(g0), .m1_grant(g1), .m_req(mreq), .s_addr(saddr), .s_wr(swr), .s_din(sdin)
  );

  bus_arbit_mux #(.ADDR_W(16), .DATA_W(32), .MAX_HOLD(0)) dut_nohold (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
    .m0_grant(n_g0), .m1_grant(n_g1), .m_req(n_mreq), .s_addr(n_saddr), .s_wr(n_swr),
    .s_din(n_sdin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m0_req, m0_wr;
    logic [15:0] m0_addr;
    logic [31:0] m0_dout;
    logic        m1_req, m1_wr;
    logic [15:0] m1_addr;
    logic [31:0] m1_dout;
    logic        exp_g0;
    logic        exp_mreq, exp_wr;
    logic [15:0] exp_addr;
    logic [31:0] exp_din;
    logic [2:0]  exp_hold;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r0, logic w0, logic [15:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [15:0] a1, logic [31:0] d1,
                              logic eg0, logic [2:0] eh);
    vec_t v;
    v.m0_req = r0; v.m0_wr = w0; v.m0_addr = a0; v.m0_dout = d0;
    v.m1_req = r1; v.m1_wr = w1; v.m1_addr = a1; v.m1_dout = d1;
    v.exp_g0   = eg0;
    v.exp_hold = eh;
    v.exp_mreq = eg0 ? r0 : r1;
    v.exp_wr   = eg0 ? w0 : w1;
    v.exp_addr = eg0 ? a0 : a1;
    v.exp_din  = eg0 ? d0 : d1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    m0_req = v.m0_req; m0_wr = v.m0_wr; m0_address = v.m0_addr; m0_dout = v.m0_dout;
    m1_req = v.m1_req; m1_wr = v.m1_wr; m1_address = v.m1_addr; m1_dout = v.m1_dout;
  endtask

  initial begin
    // Single master traffic, then handover to m1 and release back to the park owner.
    repeat (5) vecs.push_back(mk(1, 1, A0, D0, 0, 0, A1, D1, 1, 0));
    repeat (2) vecs.push_back(mk(0, 1, A0, D0, 1, 0, A1, D1, 0, 0));
    repeat (2) vecs.push_back(mk(0, 0, A0, D0, 0, 1, A1, D1, 1, 0));
    // Simultaneous first request keeps m0, then fairness alternates every 4 cycles.
    for (int i = 0; i < 12; i++)
      vecs.push_back(mk(1, 1, A0, D0, 1, 0, A1, D1, ((i + 1) / 4) % 2 == 0, 3'((i + 1) % 4)));
    vecs.push_back(mk(1, 1, A0, D0, 1, 0, A1, D1, 0, 1));
    vecs.push_back(mk(1, 1, A0, D0, 1, 0, A1, D1, 0, 2));
    vecs.push_back(mk(0, 1, A0, D0, 1, 0, A1, D1, 0, 0));  // waiting peer drops: clear
    vecs.push_back(mk(1, 1, A0, D0, 1, 0, A1, D1, 0, 1));
    vecs.push_back(mk(1, 1, A0, D0, 0, 0, A1, D1, 1, 0));

    reset = 1'b1;
    m0_req = 1'b1; m0_wr = 1'b0; m0_address = 16'h0100; m0_dout = 32'hCAFE0001;
    m1_req = 1'b1; m1_wr = 1'b1; m1_address = A1;      m1_dout = D1;
    #2;
    check("reset_m0_grant", 64'(g0), 64'd1);
    check("reset_m1_grant", 64'(g1), 64'd0);
    check("reset_s_addr", 64'(saddr), 64'h0100);
    check("reset_m_req", 64'(mreq), 64'd1);
    check("reset_s_din", 64'(sdin), 64'hCAFE0001);
    check("reset_hold", 64'(dut.hold_q), 64'd0);
    #10 reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      check($sformatf("v%0d_m0_grant", i), 64'(g0), 64'(vecs[i].exp_g0));
      check($sformatf("v%0d_m1_grant", i), 64'(g1), 64'(!vecs[i].exp_g0));
      check($sformatf("v%0d_m_req", i), 64'(mreq), 64'(vecs[i].exp_mreq));
      check($sformatf("v%0d_s_addr", i), 64'(saddr), 64'(vecs[i].exp_addr));
      check($sformatf("v%0d_s_wr", i), 64'(swr), 64'(vecs[i].exp_wr));
      check($sformatf("v%0d_s_din", i), 64'(sdin), 64'(vecs[i].exp_din));
      check($sformatf("v%0d_hold", i), 64'(dut.hold_q), 64'(vecs[i].exp_hold));
    end

    // Granted master idle while peer requests: bus shows no request until the next edge.
    m0_req = 1'b0; m1_req = 1'b1;
    #1;
    check("idle_owner_m_req", 64'(mreq), 64'd0);
    check("idle_owner_m0_grant", 64'(g0), 64'd1);
    check("idle_owner_s_addr", 64'(saddr), 64'(A0));
    @(posedge clk); #1;
    check("handover_m1_grant", 64'(g1), 64'd1);
    check("handover_s_addr", 64'(saddr), 64'(A1));

    // Asynchronous reset mid-cycle while m1 owns the bus.
    m0_address = 16'h0100;
    #2 reset = 1'b1;
    #1;
    check("async_reset_m0_grant", 64'(g0), 64'd1);
    check("async_reset_m1_grant", 64'(g1), 64'd0);
    check("async_reset_s_addr", 64'(saddr), 64'h0100);
    check("async_reset_hold", 64'(dut.hold_q), 64'd0);
    reset = 1'b0;

    // Both requesting from reset: MAX_HOLD=0 never preempts, MAX_HOLD=4 alternates.
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      check($sformatf("nohold_c%0d_m0_grant", k), 64'(n_g0), 64'd1);
      check($sformatf("nohold_c%0d_s_addr", k), 64'(n_saddr), 64'h0100);
      check($sformatf("fair_c%0d_m0_grant", k), 64'(g0), 64'((k / 4) % 2 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
